seq_div8x4: RTL and testbench

SEQ_DIV8X4 -- requirements
Module: seq_div8x4

---
 rtl/seq_div8x4.sv | 104 ++++++++++
 tb/tb_seq_div8x4.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seq_div8x4.sv
// seq_div8x4: 8/4-bit sequential restoring divider, one quotient bit per clock.
// Define SEQ_DIV8X4_ZERO_DETECT_EN to finish divide-by-zero at once and flag it on div_by_zero.
module seq_div8x4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done_flag,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [4:0] pr_q, pr_d, pr_sh, pr_nx;
  logic [7:0] dq_q, dq_d, quo_q, quo_d;
  logic [3:0] dsr_q, dsr_d, rem_q, rem_d;
  logic       hold_q, hold_d, accept, ge;
`ifdef SEQ_DIV8X4_ZERO_DETECT_EN
  logic       dbz_q, dbz_d;
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif
  // dq_q shifts dividend bits out of the top while quotient bits enter at the bottom
  assign pr_sh     = 5'({pr_q, dq_q[7]});
  assign ge        = pr_sh >= {1'b0, dsr_q};
  assign pr_nx     = ge ? pr_sh - {1'b0, dsr_q} : pr_sh;
  // hold_q blocks a start that stays high from launching a second division
  assign accept    = start && !hold_q && state_q != CALC;
  assign busy      = state_q == CALC;
  assign done_flag = state_q == DONE;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    dq_d    = dq_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    hold_d  = hold_q && start;
`ifdef SEQ_DIV8X4_ZERO_DETECT_EN
    dbz_d   = dbz_q;
`endif
    if (accept) begin
      state_d = CALC;
      cnt_d   = 3'd0;
      pr_d    = 5'd0;
      dq_d    = dividend;
      dsr_d   = divisor;
      hold_d  = 1'b1;
`ifdef SEQ_DIV8X4_ZERO_DETECT_EN
      dbz_d   = 1'b0;
      if (divisor == 4'd0) begin
        state_d = DONE;
        dbz_d   = 1'b1;
        quo_d   = 8'hFF;
        rem_d   = dividend[3:0];
      end
`endif
    end else if (state_q == CALC) begin
      pr_d  = pr_nx;
      dq_d  = {dq_q[6:0], ge};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        state_d = DONE;
        quo_d   = {dq_q[6:0], ge};
        rem_d   = pr_nx[3:0];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      pr_q    <= 5'd0;
      dq_q    <= 8'd0;
      dsr_q   <= 4'd0;
      quo_q   <= 8'd0;
      rem_q   <= 4'd0;
      hold_q  <= 1'b0;
`ifdef SEQ_DIV8X4_ZERO_DETECT_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      dq_q    <= dq_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      hold_q  <= hold_d;
`ifdef SEQ_DIV8X4_ZERO_DETECT_EN
      dbz_q   <= dbz_d;
`endif
    end
  end
endmodule

// File: tb/tb_seq_div8x4.sv
// tb_seq_div8x4: scoreboard bench for seq_div8x4 using an arithmetic reference model.
module tb_seq_div8x4;
`ifdef SEQ_DIV8X4_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif
  logic       clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [3:0] divisor = 4'd0;
  logic       busy, done_flag, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;
  int checks = 0, errors = 0, cyc = 0, n_done = 0, busy_cnt = 0, n0 = 0;
  logic done_prev = 1'b0;
  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         edge_n;
  } exp_t;
  exp_t sb[$];
  exp_t e_m;

  seq_div8x4 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done_flag(done_flag), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected edge counts the edge that samples start as edge 1.
  task automatic issue(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    e.z = ZD && b == 4'd0;
    e.q = (b == 4'd0) ? 8'hFF : 8'(int'(a) / int'(b));
    e.r = (b == 4'd0) ? a[3:0] : 4'(int'(a) % int'(b));
    e.edge_n = cyc + (e.z ? 1 : 9);
    start = 1'b1;
    dividend = a;
    divisor = b;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (busy) busy_cnt++;
      ok = sb.size() == 0;
    end
    chk("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run(input logic [7:0] a, input logic [3:0] b);
    issue(a, b);
    wait_done();
  endtask

  always @(negedge clk) begin
    if (rst_n && done_flag &&
        (!done_prev || (sb.size() != 0 && sb[0].z && cyc == sb[0].edge_n))) begin
      n_done++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: q=%0d r=%0d with no request pending", quotient, remainder);
      end else begin
        e_m = sb.pop_front();
        chk("quotient", quotient, e_m.q);
        chk("remainder", remainder, e_m.r);
        chk("div_by_zero", div_by_zero, e_m.z);
        chk("latency_edge", cyc, e_m.edge_n);
        if (e_m.b != 4'd0) begin
          chk("identity", int'(quotient) * int'(e_m.b) + int'(remainder), e_m.a);
          chk("rem_lt_div", remainder < e_m.b, 1);
        end
      end
    end
    done_prev = done_flag;
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done_flag, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'd200, 4'd7);
    wait_done();
    chk("busy_cycles", busy_cnt, 8);
    run(8'd255, 4'd15);
    run(8'd13, 4'd1);
    run(8'd5, 4'd9);
    run(8'd0, 4'd3);
    run(8'hA7, 4'd0);
    run(8'hA7, 4'd0);
    issue(8'd100, 4'd3);
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b1;
    dividend = 8'd50;
    divisor = 4'd5;
    wait_done();
    issue(8'd200, 4'd7);
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    n0 = n_done;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done_flag, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_done", n_done, n0);
    run(8'd9, 4'd2);
    issue(8'd77, 4'd6);
    @(posedge clk);
    #1;
    chk("b2b_done_drop", done_flag, 0);
    wait_done();
    n0 = n_done;
    issue(8'd40, 4'd3);
    repeat (20) @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("held_start_ops", n_done - n0, 1);
    chk("held_start_drain", sb.size(), 0);
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 16; b++)
        run(8'(a), 4'(b));
    for (int i = 0; i < 200; i++)
      run(8'($urandom_range(255)), 4'($urandom_range(15)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
